// File: rtl/elevator_pkg.sv
// Shared types and defaults for the elevator sequencing stage.
package elevator_pkg;

  localparam int unsigned FLOOR_W           = 4;
  localparam int unsigned N_FLOORS_DEF      = 16;
  localparam int unsigned FLOOR_TICKS_DEF   = 8;
  localparam int unsigned DOOR_TICKS_DEF    = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EVAL,
    ST_MOVE_UP,
    ST_MOVE_DOWN,
    ST_DOOR
  } state_t;

  // Counter width covering the larger of the travel and door periods.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/elevator_tick_cnt.sv
// Loadable down-counter with zero flag, shared by travel and door timing.
module elevator_tick_cnt #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/elevator_fsm.sv
// Elevator sequencer: latches a floor request, steps position one floor at a
// time under motor drive, then holds the door open before accepting again.
module elevator_fsm
  import elevator_pkg::*;
#(
  parameter int unsigned N_FLOORS    = N_FLOORS_DEF,
  parameter int unsigned FLOOR_TICKS = FLOOR_TICKS_DEF,
  parameter int unsigned DOOR_TICKS  = DOOR_TICKS_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_fsm_req_valid,
  input  logic [FLOOR_W-1:0] i_fsm_req_floor,
  output logic               o_fsm_req_ready,
  output logic [FLOOR_W-1:0] o_fsm_floor_no,
  output logic [FLOOR_W-1:0] o_fsm_current_floor,
  input  logic               i_fsm_move_up,
  input  logic               i_fsm_move_down,
  input  logic               i_fsm_equal,
  output logic               o_fsm_motor_up,
  output logic               o_fsm_motor_down,
  output logic               o_fsm_door_open,
  output logic               o_fsm_busy
);

  localparam int unsigned        CNT_W       = cnt_width(FLOOR_TICKS, DOOR_TICKS);
  localparam logic [CNT_W-1:0]   FLOOR_LOAD  = CNT_W'(FLOOR_TICKS - 1);
  localparam logic [CNT_W-1:0]   DOOR_LOAD   = CNT_W'(DOOR_TICKS - 1);
  localparam logic [FLOOR_W-1:0] TOP_FLOOR   = FLOOR_W'(N_FLOORS - 1);
  localparam logic [FLOOR_W:0]   FLOOR_LIMIT = (FLOOR_W + 1)'(N_FLOORS);

  state_t           state;
  logic             cnt_load;
  logic             cnt_en;
  logic             cnt_zero;
  logic [CNT_W-1:0] cnt_load_val;

  // The counter is armed in EVAL, the cycle before the motor or door starts.
  assign cnt_load     = (state == ST_EVAL);
  assign cnt_load_val = i_fsm_equal ? DOOR_LOAD : FLOOR_LOAD;
  assign cnt_en       = (state == ST_MOVE_UP) || (state == ST_MOVE_DOWN) || (state == ST_DOOR);

  elevator_tick_cnt #(
    .W (CNT_W)
  ) u_tick_cnt (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .en       (cnt_en),
    .zero     (cnt_zero)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state               <= ST_IDLE;
      o_fsm_current_floor <= '0;
      o_fsm_floor_no      <= '0;
      o_fsm_req_ready     <= 1'b1;
      o_fsm_busy          <= 1'b0;
      o_fsm_motor_up      <= 1'b0;
      o_fsm_motor_down    <= 1'b0;
      o_fsm_door_open     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_fsm_req_valid && ({1'b0, i_fsm_req_floor} < FLOOR_LIMIT)) begin
            o_fsm_floor_no  <= i_fsm_req_floor;
            state           <= ST_EVAL;
            o_fsm_req_ready <= 1'b0;
            o_fsm_busy      <= 1'b1;
          end
        end
        ST_EVAL: begin
          if (i_fsm_equal) begin
            state           <= ST_DOOR;
            o_fsm_door_open <= 1'b1;
          end else if (i_fsm_move_up) begin
            state          <= ST_MOVE_UP;
            o_fsm_motor_up <= 1'b1;
          end else if (i_fsm_move_down) begin
            state            <= ST_MOVE_DOWN;
            o_fsm_motor_down <= 1'b1;
          end else begin
            state           <= ST_IDLE;
            o_fsm_req_ready <= 1'b1;
            o_fsm_busy      <= 1'b0;
          end
        end
        ST_MOVE_UP: begin
          if (cnt_zero) begin
            if (o_fsm_current_floor != TOP_FLOOR) begin
              o_fsm_current_floor <= o_fsm_current_floor + 1'b1;
            end
            state          <= ST_EVAL;
            o_fsm_motor_up <= 1'b0;
          end
        end
        ST_MOVE_DOWN: begin
          if (cnt_zero) begin
            if (o_fsm_current_floor != '0) begin
              o_fsm_current_floor <= o_fsm_current_floor - 1'b1;
            end
            state            <= ST_EVAL;
            o_fsm_motor_down <= 1'b0;
          end
        end
        ST_DOOR: begin
          if (cnt_zero) begin
            state           <= ST_IDLE;
            o_fsm_door_open <= 1'b0;
            o_fsm_req_ready <= 1'b1;
            o_fsm_busy      <= 1'b0;
          end
        end
        default: begin
          state            <= ST_IDLE;
          o_fsm_req_ready  <= 1'b1;
          o_fsm_busy       <= 1'b0;
          o_fsm_motor_up   <= 1'b0;
          o_fsm_motor_down <= 1'b0;
          o_fsm_door_open  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_elevator_fsm.sv
// Bench for elevator_fsm: two instances (16 and 10 floors) closed-loop with a
// floor comparator, checked each cycle against a per-trip schedule model.
module tb_elevator_fsm;

  typedef struct packed {
    logic       ready;
    logic       busy;
    logic       mu;
    logic       md;
    logic       door;
    logic [3:0] cur;
    logic [3:0] fno;
  } exp_t;

  localparam int FT = 8;
  localparam int DT = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid;
  logic [3:0] req_floor;

  logic       a_ready, a_busy, a_mu, a_md, a_door, a_up, a_dn, a_eq;
  logic [3:0] a_cur, a_fno;
  logic       b_ready, b_busy, b_mu, b_md, b_door, b_up, b_dn, b_eq;
  logic [3:0] b_cur, b_fno;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign a_up = a_fno > a_cur;
  assign a_dn = a_fno < a_cur;
  assign a_eq = a_fno == a_cur;
  assign b_up = b_fno > b_cur;
  assign b_dn = b_fno < b_cur;
  assign b_eq = b_fno == b_cur;

  elevator_fsm dut_a (
    .i_clk (clk), .i_rst_n (rst_n),
    .i_fsm_req_valid (valid), .i_fsm_req_floor (req_floor),
    .o_fsm_req_ready (a_ready), .o_fsm_floor_no (a_fno), .o_fsm_current_floor (a_cur),
    .i_fsm_move_up (a_up), .i_fsm_move_down (a_dn), .i_fsm_equal (a_eq),
    .o_fsm_motor_up (a_mu), .o_fsm_motor_down (a_md), .o_fsm_door_open (a_door),
    .o_fsm_busy (a_busy)
  );

  elevator_fsm #(.N_FLOORS(10), .FLOOR_TICKS(8), .DOOR_TICKS(4)) dut_b (
    .i_clk (clk), .i_rst_n (rst_n),
    .i_fsm_req_valid (valid), .i_fsm_req_floor (req_floor),
    .o_fsm_req_ready (b_ready), .o_fsm_floor_no (b_fno), .o_fsm_current_floor (b_cur),
    .i_fsm_move_up (b_up), .i_fsm_move_down (b_dn), .i_fsm_equal (b_eq),
    .o_fsm_motor_up (b_mu), .o_fsm_motor_down (b_md), .o_fsm_door_open (b_door),
    .o_fsm_busy (b_busy)
  );

  // Reference model: on acceptance, the whole trip is expanded into a queue of
  // per-cycle expected outputs; an empty queue means idle.
  exp_t q0[$];
  exp_t q1[$];
  logic [3:0] m_cur [2];
  logic [3:0] m_fno [2];
  int         nf    [2] = '{16, 10};

  logic       s_rst = 1'b1;
  logic       s_valid = 1'b0;
  logic [3:0] s_floor = '0;
  bit         model_on = 1'b0;

  always @(posedge clk) begin
    s_rst   <= rst_n;
    s_valid <= valid;
    s_floor <= req_floor;
  end

  task automatic push_e(input int inst, input exp_t e);
    if (inst == 0) q0.push_back(e);
    else           q1.push_back(e);
  endtask

  task automatic build(input int inst, input logic [3:0] from, input logic [3:0] t);
    int  c;
    bit  up;
    c = int'(from);
    push_e(inst, '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'(c), t});
    while (c != int'(t)) begin
      up = int'(t) > c;
      repeat (FT) push_e(inst, '{1'b0, 1'b1, up, !up, 1'b0, 4'(c), t});
      c = up ? c + 1 : c - 1;
      push_e(inst, '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'(c), t});
    end
    repeat (DT) push_e(inst, '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, t, t});
  endtask

  function automatic int qsize(input int inst);
    return (inst == 0) ? q0.size() : q1.size();
  endfunction

  task automatic step(input int inst, output exp_t e);
    if (!s_rst) begin
      if (inst == 0) q0.delete(); else q1.delete();
      m_cur[inst] = '0;
      m_fno[inst] = '0;
    end else if (qsize(inst) > 0) begin
      if (inst == 0) void'(q0.pop_front()); else void'(q1.pop_front());
    end else if (s_valid && (int'(s_floor) < nf[inst])) begin
      m_fno[inst] = s_floor;
      build(inst, m_cur[inst], s_floor);
      m_cur[inst] = s_floor;
    end
    if (qsize(inst) > 0) e = (inst == 0) ? q0[0] : q1[0];
    else e = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, m_cur[inst], m_fno[inst]};
  endtask

  always @(negedge clk) begin
    exp_t ea, eb, ga, gb;
    if (!s_rst) model_on = 1'b1;
    if (model_on) begin
      step(0, ea);
      step(1, eb);
      ga = '{a_ready, a_busy, a_mu, a_md, a_door, a_cur, a_fno};
      gb = '{b_ready, b_busy, b_mu, b_md, b_door, b_cur, b_fno};
      checks++;
      if (ga !== ea) begin
        errors++;
        $display("FAIL cycle_a t=%0t got rdy/bsy/up/dn/door/cur/fno=%b expected %b", $time, ga, ea);
      end
      checks++;
      if (gb !== eb) begin
        errors++;
        $display("FAIL cycle_b t=%0t got rdy/bsy/up/dn/door/cur/fno=%b expected %b", $time, gb, eb);
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 400; i++) begin
      if (a_busy === 1'b0 && b_busy === 1'b0) break;
      @(negedge clk);
    end
    if (a_busy !== 1'b0 || b_busy !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout got busy=%b/%b expected 0", name, a_busy, b_busy);
    end
  endtask

  task automatic run_trip(input logic [3:0] f, input int pulse_at,
                          output int busy_n, output int up_n, output int dn_n, output int door_n);
    busy_n = 0; up_n = 0; dn_n = 0; door_n = 0;
    @(negedge clk); valid = 1'b1; req_floor = f;
    @(negedge clk); valid = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (a_busy !== 1'b1) break;
      busy_n++;
      up_n   += int'(a_mu);
      dn_n   += int'(a_md);
      door_n += int'(a_door);
      if (i == pulse_at) begin valid = 1'b1; req_floor = 4'd7; end
      else valid = 1'b0;
      @(negedge clk);
    end
    valid = 1'b0;
    wait_idle("trip");
  endtask

  initial begin
    int bn, un, dn, drn;
    rst_n = 1'b0; valid = 1'b0; req_floor = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_ready", int'(a_ready), 1);
    chk("reset_busy", int'(a_busy), 0);
    chk("reset_cur", int'(a_cur), 0);
    chk("reset_fno", int'(a_fno), 0);
    chk("reset_outs", int'({a_mu, a_md, a_door}), 0);

    run_trip(4'd4, 15, bn, un, dn, drn);
    chk("up4_busy_cycles", bn, 41);
    chk("up4_motor_up", un, 32);
    chk("up4_motor_down", dn, 0);
    chk("up4_door", drn, 4);
    chk("up4_cur", int'(a_cur), 4);
    chk("up4_fno_after_pulse", int'(a_fno), 4);

    run_trip(4'd1, -1, bn, un, dn, drn);
    chk("dn1_busy_cycles", bn, 32);
    chk("dn1_motor_down", dn, 24);
    chk("dn1_motor_up", un, 0);
    chk("dn1_door", drn, 4);
    chk("dn1_cur", int'(a_cur), 1);

    run_trip(4'd1, -1, bn, un, dn, drn);
    chk("same_busy_cycles", bn, 5);
    chk("same_motor", un + dn, 0);
    chk("same_door", drn, 4);

    @(negedge clk); valid = 1'b1; req_floor = 4'd12;
    @(negedge clk); valid = 1'b0;
    chk("n10_oob_busy", int'(b_busy), 0);
    chk("n10_oob_ready", int'(b_ready), 1);
    chk("n10_oob_fno", int'(b_fno), 1);
    chk("n16_req12_busy", int'(a_busy), 1);
    wait_idle("req12");
    chk("n16_req12_cur", int'(a_cur), 12);

    @(negedge clk); valid = 1'b1; req_floor = 4'd15;
    @(negedge clk); valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("midmove_motor_up", int'(a_mu), 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midmove_rst_cur", int'(a_cur), 0);
    chk("midmove_rst_mu", int'(a_mu), 0);
    chk("midmove_rst_ready", int'(a_ready), 1);
    chk("midmove_rst_fno", int'(a_fno), 0);

    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      rst_n     = ($urandom_range(0, 399) != 0);
      valid     = ($urandom_range(0, 7) == 0);
      req_floor = 4'($urandom_range(0, 15));
    end
    @(negedge clk);
    rst_n = 1'b1; valid = 1'b0;
    wait_idle("final");
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
